// File: rtl/credit_sender.sv
// Transmit end of a credit-flow-controlled link: valid/ready stream in, valid-only pulses out,
// with a saturating credit counter gating the write side.
module credit_sender #(
    parameter int  DATA_WIDTH = 1,
    parameter type TYPE       = logic [DATA_WIDTH-1:0],
    parameter int  CREDITS    = 2,
    parameter int  OUTPUT_REG = 1,
    parameter int  RETURN_REG = 0
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         w_valid,
    output logic                         w_ready,
    input  TYPE                          w_data,
    output logic                         tx_valid,
    output TYPE                          tx_data,
    input  logic                         credit_return,
    output logic [$clog2(CREDITS+1)-1:0] credit_count,
    output logic                         idle,
    output logic                         overflow
);

    localparam int            CW   = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    logic [CW-1:0] cnt_p0;
    logic          fire;
    logic          ret;
    logic          ret_pend;

    // Simultaneous send and return cancel; returns into a full counter saturate.
    function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cnt,
                                                 input logic f, input logic r);
        if (f && !r)
            return cnt - CW'(1);
        if (!f && r && cnt != FULL)
            return cnt + CW'(1);
        return cnt;
    endfunction

    assign w_ready      = (cnt_p0 != '0);
    assign fire         = w_valid && w_ready;
    assign credit_count = cnt_p0;

    // Return stage: optional register in front of the counter
    if (RETURN_REG != 0) begin : g_ret_reg
        logic ret_p1;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)
                ret_p1 <= 1'b0;
            else
                ret_p1 <= credit_return;
        end
        assign ret      = ret_p1;
        assign ret_pend = ret_p1;
    end else begin : g_ret_comb
        assign ret      = credit_return;
        assign ret_pend = 1'b0;
    end

    // Counter stage
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt_p0 <= FULL;
        else
            cnt_p0 <= next_count(cnt_p0, fire, ret);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            overflow <= 1'b0;
        else if (ret && !fire && cnt_p0 == FULL)
            overflow <= 1'b1;
    end

    // Output stage: registered or pass-through
    if (OUTPUT_REG != 0) begin : g_out_reg
        logic tx_valid_p1;
        TYPE  tx_data_p1;
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn)
                tx_valid_p1 <= 1'b0;
            else
                tx_valid_p1 <= fire;
        end
        always_ff @(posedge clk) begin
            if (fire)
                tx_data_p1 <= w_data;
        end
        assign tx_valid = tx_valid_p1;
        assign tx_data  = tx_data_p1;
    end else begin : g_out_comb
        assign tx_valid = fire;
        assign tx_data  = w_data;
    end

    assign idle = (cnt_p0 == FULL) && !tx_valid && !ret_pend;

endmodule

// File: tb/tb_credit_sender.sv
// Bench for credit_sender: three configurations share one stimulus stream and are checked every
// cycle against a credit-arithmetic model, plus directed literal checks from the test plan.
module tb_credit_sender;

    logic       clk = 1'b0;
    logic       rstn;
    logic       w_valid;
    logic [7:0] w_data;
    logic       credit_return;

    logic       rdy [3];
    logic       tv  [3];
    logic       idl [3];
    logic       ov  [3];
    logic [7:0] td  [3];
    logic [1:0] cc  [3];
    logic [1:0] cc0;
    logic [0:0] cc1;
    logic [1:0] cc2;

    assign cc[0] = cc0;
    assign cc[1] = {1'b0, cc1};
    assign cc[2] = cc2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    credit_sender #(.DATA_WIDTH(8), .CREDITS(2), .OUTPUT_REG(1), .RETURN_REG(0)) dut0 (
        .clk(clk), .rstn(rstn), .w_valid(w_valid), .w_ready(rdy[0]), .w_data(w_data),
        .tx_valid(tv[0]), .tx_data(td[0]), .credit_return(credit_return),
        .credit_count(cc0), .idle(idl[0]), .overflow(ov[0]));

    credit_sender #(.DATA_WIDTH(8), .CREDITS(1), .OUTPUT_REG(1), .RETURN_REG(1)) dut1 (
        .clk(clk), .rstn(rstn), .w_valid(w_valid), .w_ready(rdy[1]), .w_data(w_data),
        .tx_valid(tv[1]), .tx_data(td[1]), .credit_return(credit_return),
        .credit_count(cc1), .idle(idl[1]), .overflow(ov[1]));

    credit_sender #(.DATA_WIDTH(8), .CREDITS(3), .OUTPUT_REG(0), .RETURN_REG(1)) dut2 (
        .clk(clk), .rstn(rstn), .w_valid(w_valid), .w_ready(rdy[2]), .w_data(w_data),
        .tx_valid(tv[2]), .tx_data(td[2]), .credit_return(credit_return),
        .credit_count(cc2), .idle(idl[2]), .overflow(ov[2]));

    function automatic int mc(int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 3;
    endfunction
    function automatic bit mo(int k);
        return (k != 2);
    endfunction
    function automatic bit mr(int k);
        return (k != 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: available credits as plain integers, returns optionally delayed one cycle.
    int         m_cnt [3];
    bit         m_rq  [3];
    bit         m_txv [3];
    bit         m_ovf [3];
    logic [7:0] m_txd [3];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 3; k++) begin
                m_cnt[k] <= mc(k);
                m_rq[k]  <= 1'b0;
                m_txv[k] <= 1'b0;
                m_ovf[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                bit f, r;
                int n;
                f = w_valid && (m_cnt[k] > 0);
                r = mr(k) ? m_rq[k] : credit_return;
                n = m_cnt[k] - int'(f) + int'(r);
                if (n > mc(k)) n = mc(k);
                if (r && !f && m_cnt[k] == mc(k)) m_ovf[k] <= 1'b1;
                m_cnt[k] <= n;
                m_rq[k]  <= credit_return;
                m_txv[k] <= f;
                if (f) m_txd[k] <= w_data;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            bit         f, txv_e, idle_e;
            logic [7:0] txd_e;
            f      = w_valid && (m_cnt[k] > 0);
            txv_e  = mo(k) ? m_txv[k] : f;
            txd_e  = mo(k) ? m_txd[k] : w_data;
            idle_e = (m_cnt[k] == mc(k)) && !txv_e && !(mr(k) && m_rq[k]);
            chk($sformatf("d%0d_ready", k), 32'(rdy[k]), 32'(m_cnt[k] > 0));
            chk($sformatf("d%0d_count", k), 32'(cc[k]), 32'(m_cnt[k]));
            chk($sformatf("d%0d_txvalid", k), 32'(tv[k]), 32'(txv_e));
            chk($sformatf("d%0d_idle", k), 32'(idl[k]), 32'(idle_e));
            chk($sformatf("d%0d_overflow", k), 32'(ov[k]), 32'(m_ovf[k]));
            if (txv_e)
                chk($sformatf("d%0d_txdata", k), 32'(td[k]), 32'(txd_e));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int pulses;

    initial begin
        rstn = 1'b0; w_valid = 1'b0; w_data = 8'h00; credit_return = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_ready", 32'(rdy[0]), 1); chk("rst_count", 32'(cc0), 2);
        chk("rst_idle", 32'(idl[0]), 1);  chk("rst_txvalid", 32'(tv[0]), 0);
        chk("rst_overflow", 32'(ov[0]), 0);
        next_cycle();

        // Back-to-back beats, CREDITS=2
        w_valid = 1'b1; w_data = 8'h0A;
        @(negedge clk); chk("b2b_c0_ready", 32'(rdy[0]), 1); chk("b2b_c0_txv", 32'(tv[0]), 0);
        next_cycle(); w_data = 8'h0B;
        @(negedge clk); chk("b2b_c1_txv", 32'(tv[0]), 1); chk("b2b_c1_data", 32'(td[0]), 32'h0A);
        chk("b2b_c1_count", 32'(cc0), 1);
        next_cycle(); w_data = 8'h0C;
        @(negedge clk); chk("b2b_c2_txv", 32'(tv[0]), 1); chk("b2b_c2_data", 32'(td[0]), 32'h0B);
        chk("b2b_c2_ready", 32'(rdy[0]), 0); chk("b2b_c2_count", 32'(cc0), 0);
        next_cycle();
        @(negedge clk); chk("b2b_c3_txv", 32'(tv[0]), 0); chk("b2b_c3_ready", 32'(rdy[0]), 0);
        next_cycle(); credit_return = 1'b1;
        @(negedge clk); chk("b2b_c4_ready", 32'(rdy[0]), 0);
        next_cycle(); credit_return = 1'b0;
        @(negedge clk); chk("b2b_c5_ready", 32'(rdy[0]), 1); chk("b2b_c5_count", 32'(cc0), 1);
        next_cycle(); w_valid = 1'b0;
        @(negedge clk); chk("b2b_c6_txv", 32'(tv[0]), 1); chk("b2b_c6_data", 32'(td[0]), 32'h0C);
        chk("b2b_c6_count", 32'(cc0), 0);
        next_cycle();

        // Simultaneous fire and return at counter=1
        credit_return = 1'b1;
        next_cycle();
        w_valid = 1'b1; w_data = 8'h5A;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("simul_count", 32'(cc0), 1); chk("simul_ready", 32'(rdy[0]), 1);
            if (tv[0]) pulses++;
            next_cycle();
        end
        w_valid = 1'b0; credit_return = 1'b0;
        @(negedge clk);
        if (tv[0]) pulses++;
        chk("simul_pulses", 32'(pulses), 10); chk("simul_final_count", 32'(cc0), 1);
        next_cycle();

        // Overflow: one legal return to fill, then one too many
        credit_return = 1'b1;
        next_cycle(); credit_return = 1'b0;
        @(negedge clk); chk("ovf_full_count", 32'(cc0), 2); chk("ovf_before", 32'(ov[0]), 0);
        next_cycle(); credit_return = 1'b1;
        next_cycle(); credit_return = 1'b0;
        @(negedge clk); chk("ovf_count_sat", 32'(cc0), 2); chk("ovf_set", 32'(ov[0]), 1);
        repeat (3) next_cycle();
        @(negedge clk); chk("ovf_sticky", 32'(ov[0]), 1);
        next_cycle(); rstn = 1'b0;
        @(negedge clk); chk("ovf_cleared", 32'(ov[0]), 0);
        next_cycle(); rstn = 1'b1;

        // RETURN_REG=1, CREDITS=1 (dut1)
        w_valid = 1'b1; w_data = 8'h33;
        next_cycle(); w_valid = 1'b0;
        @(negedge clk); chk("rr_sent_count", 32'(cc1), 0); chk("rr_sent_txv", 32'(tv[1]), 1);
        next_cycle(); credit_return = 1'b1;
        @(negedge clk); chk("rr_t_count", 32'(cc1), 0); chk("rr_t_idle", 32'(idl[1]), 0);
        next_cycle(); credit_return = 1'b0;
        @(negedge clk); chk("rr_t1_count", 32'(cc1), 0); chk("rr_t1_idle", 32'(idl[1]), 0);
        chk("rr_t1_ready", 32'(rdy[1]), 0);
        next_cycle();
        @(negedge clk); chk("rr_t2_count", 32'(cc1), 1); chk("rr_t2_ready", 32'(rdy[1]), 1);
        chk("rr_t2_idle", 32'(idl[1]), 1);
        next_cycle();

        // Async reset mid-stream with credit_count=0 and tx_valid=1 (dut0)
        w_valid = 1'b1; w_data = 8'h11;
        next_cycle(); w_data = 8'h22;
        next_cycle(); w_valid = 1'b0;
        #2;
        chk("arst_pre_txv", 32'(tv[0]), 1); chk("arst_pre_count", 32'(cc0), 0);
        rstn = 1'b0;
        #1;
        chk("arst_txv", 32'(tv[0]), 0); chk("arst_count", 32'(cc0), 2);
        chk("arst_ready", 32'(rdy[0]), 1); chk("arst_idle", 32'(idl[0]), 1);
        @(negedge clk); #2 rstn = 1'b1;
        @(negedge clk); chk("arst_rel_count", 32'(cc0), 2); chk("arst_rel_ready", 32'(rdy[0]), 1);
        next_cycle();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            w_valid       = ($urandom_range(0, 3) != 0);
            w_data        = 8'($urandom);
            credit_return = ($urandom_range(0, 2) == 0);
            rstn          = ($urandom_range(0, 299) != 0);
            next_cycle();
        end
        rstn = 1'b1; w_valid = 1'b0; credit_return = 1'b0;
        repeat (2) next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
